// File: rtl/pc_sequencer.sv
// Registered program-counter sequencer: J/JZ/JNZ/CALL/RET/HALT decode, hardware
// return-address stack, halt/resume and stall control, sticky stack-fault state.
module pc_sequencer #(
    parameter int  PC_W        = 10,
    parameter int  STACK_DEPTH = 8,
    localparam int SPW         = $clog2(STACK_DEPTH + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [5:0]      opcode,
    input  logic [PC_W-1:0] jump_addr,
    input  logic            z,
    input  logic            stall,
    input  logic            resume,
    output logic [PC_W-1:0] pc,
    output logic [SPW-1:0]  sp,
    output logic            halted,
    output logic            fault,
    output logic [1:0]      fault_code
);

    localparam int             AW      = $clog2(STACK_DEPTH);
    localparam logic [SPW-1:0] SP_FULL = SPW'(STACK_DEPTH);

    localparam logic [5:0] OP_J    = 6'b001000;
    localparam logic [5:0] OP_JZ   = 6'b001001;
    localparam logic [5:0] OP_JNZ  = 6'b001010;
    localparam logic [5:0] OP_CALL = 6'b001011;
    localparam logic [5:0] OP_RET  = 6'b001100;
    localparam logic [5:0] OP_HALT = 6'b001111;

    localparam logic [1:0] FC_NONE      = 2'b00;
    localparam logic [1:0] FC_OVERFLOW  = 2'b01;
    localparam logic [1:0] FC_UNDERFLOW = 2'b10;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_HALT,
        ST_FAULT
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_nxt;
    logic [PC_W-1:0] w_pc_inc;
    logic [SPW-1:0]  r_sp;
    logic [SPW-1:0]  w_sp_nxt;
    logic [1:0]      r_fault_code;
    logic [1:0]      w_fault_code_nxt;
    logic            w_push;
    logic [AW-1:0]   w_push_idx;
    logic [AW-1:0]   w_top_idx;
    logic [PC_W-1:0] r_stack [STACK_DEPTH];

    // Addition wraps naturally at PC_W bits, so pc=all-ones increments to 0.
    assign w_pc_inc   = r_pc + PC_W'(1);
    assign w_push_idx = AW'(r_sp);
    assign w_top_idx  = AW'(r_sp - SPW'(1));

    // NOTE: every next-state signal gets its hold value first so no path through
    // the case statements can leave one unassigned and infer a latch.
    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_sp_nxt         = r_sp;
        w_fault_code_nxt = r_fault_code;
        w_push           = 1'b0;
        if (!stall) begin
            unique case (r_state)
                ST_RUN: begin
                    unique case (opcode)
                        OP_J:   w_pc_nxt = jump_addr;
                        OP_JZ:  w_pc_nxt = z ? jump_addr : w_pc_inc;
                        OP_JNZ: w_pc_nxt = z ? w_pc_inc : jump_addr;
                        OP_CALL: begin
                            if (r_sp < SP_FULL) begin
                                w_push   = 1'b1;
                                w_sp_nxt = r_sp + SPW'(1);
                                w_pc_nxt = jump_addr;
                            end else begin
                                w_state_nxt      = ST_FAULT;
                                w_fault_code_nxt = FC_OVERFLOW;
                            end
                        end
                        OP_RET: begin
                            if (r_sp != '0) begin
                                w_sp_nxt = r_sp - SPW'(1);
                                w_pc_nxt = r_stack[w_top_idx];
                            end else begin
                                w_state_nxt      = ST_FAULT;
                                w_fault_code_nxt = FC_UNDERFLOW;
                            end
                        end
                        OP_HALT: w_state_nxt = ST_HALT;
                        default: w_pc_nxt = w_pc_inc;
                    endcase
                end
                ST_HALT: begin
                    if (resume) begin
                        w_pc_nxt    = w_pc_inc;
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_FAULT: ;
                default:  w_state_nxt = ST_FAULT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_RUN;
            r_pc         <= '0;
            r_sp         <= '0;
            r_fault_code <= FC_NONE;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_sp         <= w_sp_nxt;
            r_fault_code <= w_fault_code_nxt;
        end
    end

    // NOTE: the stack array is deliberately not reset; entries above sp are never
    // read, and leaving it reset-free lets it map onto plain RAM/register-file cells.
    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            r_stack[w_push_idx] <= w_pc_inc;
        end
    end

    assign pc         = r_pc;
    assign sp         = r_sp;
    assign halted     = (r_state == ST_HALT);
    assign fault      = (r_state == ST_FAULT);
    assign fault_code = r_fault_code;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed test-plan scenarios with literal
// expectations, then randomized traffic checked every cycle against a queue model.
module tb_pc_sequencer;

    localparam int PC_W        = 10;
    localparam int STACK_DEPTH = 8;
    localparam int SPW         = $clog2(STACK_DEPTH + 1);
    localparam int PC_MOD      = 1 << PC_W;

    localparam logic [5:0] OP_J    = 6'b001000;
    localparam logic [5:0] OP_JZ   = 6'b001001;
    localparam logic [5:0] OP_JNZ  = 6'b001010;
    localparam logic [5:0] OP_CALL = 6'b001011;
    localparam logic [5:0] OP_RET  = 6'b001100;
    localparam logic [5:0] OP_HALT = 6'b001111;
    localparam logic [5:0] OP_MOV  = 6'b100000;

    logic            clk;
    logic            reset;
    logic [5:0]      opcode;
    logic [PC_W-1:0] jump_addr;
    logic            z;
    logic            stall;
    logic            resume;
    logic [PC_W-1:0] pc;
    logic [SPW-1:0]  sp;
    logic            halted;
    logic            fault;
    logic [1:0]      fault_code;

    pc_sequencer #(
        .PC_W       (PC_W),
        .STACK_DEPTH(STACK_DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .opcode    (opcode),
        .jump_addr (jump_addr),
        .z         (z),
        .stall     (stall),
        .resume    (resume),
        .pc        (pc),
        .sp        (sp),
        .halted    (halted),
        .fault     (fault),
        .fault_code(fault_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: mode 0=run, 1=halt, 2=fault; the stack is a plain queue.
    int m_pc;
    int m_mode;
    int m_fc;
    int m_stack[$];

    function automatic void model_step(input bit rst, input logic [5:0] op,
                                       input int addr, input bit zz,
                                       input bit st, input bit rs);
        if (rst) begin
            m_pc   = 0;
            m_mode = 0;
            m_fc   = 0;
            m_stack.delete();
        end else if (!st) begin
            if (m_mode == 0) begin
                if (op == OP_J) m_pc = addr;
                else if (op == OP_JZ) m_pc = zz ? addr : (m_pc + 1) % PC_MOD;
                else if (op == OP_JNZ) m_pc = zz ? (m_pc + 1) % PC_MOD : addr;
                else if (op == OP_CALL) begin
                    if (m_stack.size() < STACK_DEPTH) begin
                        m_stack.push_back((m_pc + 1) % PC_MOD);
                        m_pc = addr;
                    end else begin
                        m_mode = 2;
                        m_fc   = 1;
                    end
                end else if (op == OP_RET) begin
                    if (m_stack.size() > 0) m_pc = m_stack.pop_back();
                    else begin
                        m_mode = 2;
                        m_fc   = 2;
                    end
                end else if (op == OP_HALT) m_mode = 1;
                else m_pc = (m_pc + 1) % PC_MOD;
            end else if (m_mode == 1 && rs) begin
                m_pc   = (m_pc + 1) % PC_MOD;
                m_mode = 0;
            end
        end
    endfunction

    // Called just after a falling edge; applies one instruction cycle and returns
    // at the next falling edge, when the registered outputs are settled.
    task automatic step(input bit rst, input logic [5:0] op, input int addr,
                        input bit zz, input bit st, input bit rs);
        reset     = rst;
        opcode    = op;
        jump_addr = PC_W'(addr);
        z         = zz;
        stall     = st;
        resume    = rs;
        @(posedge clk);
        model_step(rst, op, addr, zz, st, rs);
        @(negedge clk);
    endtask

    task automatic op_step(input logic [5:0] op, input int addr);
        step(1'b0, op, addr, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b1, OP_MOV, 0, 1'b0, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_pc", 32'(pc), 32'(m_pc));
            check("model_sp", 32'(sp), 32'(m_stack.size()));
            check("model_halted", 32'(halted), 32'(m_mode == 1));
            check("model_fault", 32'(fault), 32'(m_mode == 2));
            check("model_fault_code", 32'(fault_code), 32'(m_fc));
        end
    end

    initial begin
        reset     = 1'b1;
        opcode    = OP_MOV;
        jump_addr = '0;
        z         = 1'b0;
        stall     = 1'b0;
        resume    = 1'b0;
        @(negedge clk);
        do_reset();
        cmp_en = 1'b1;
        check("reset_pc", 32'(pc), 32'h0);
        check("reset_flags", {29'd0, halted, fault_code}, 32'h0);

        for (int i = 0; i < 5; i++) op_step(OP_MOV, 0);
        check("seq_pc5", 32'(pc), 32'h5);
        check("seq_sp", 32'(sp), 32'h0);

        op_step(OP_J, 3);
        step(1'b0, OP_JZ, 'h40, 1'b1, 1'b0, 1'b0);
        check("jz_taken", 32'(pc), 32'h40);
        op_step(OP_J, 3);
        step(1'b0, OP_JZ, 'h40, 1'b0, 1'b0, 1'b0);
        check("jz_not_taken", 32'(pc), 32'h4);
        op_step(OP_J, 3);
        step(1'b0, OP_JNZ, 'h40, 1'b1, 1'b0, 1'b0);
        check("jnz_not_taken", 32'(pc), 32'h4);
        op_step(OP_J, 3);
        step(1'b0, OP_JNZ, 'h40, 1'b0, 1'b0, 1'b0);
        check("jnz_taken", 32'(pc), 32'h40);

        op_step(OP_J, 'h10);
        op_step(OP_CALL, 'h100);
        op_step(OP_CALL, 'h200);
        check("nest_sp2", 32'(sp), 32'h2);
        op_step(OP_RET, 0);
        check("ret1_pc", 32'(pc), 32'h101);
        check("ret1_sp", 32'(sp), 32'h1);
        op_step(OP_RET, 0);
        check("ret2_pc", 32'(pc), 32'h11);
        check("ret2_sp", 32'(sp), 32'h0);

        for (int i = 0; i < STACK_DEPTH; i++) op_step(OP_CALL, 'h50);
        check("full_sp", 32'(sp), 32'h8);
        check("full_nofault", 32'(fault), 32'h0);
        op_step(OP_CALL, 'h77);
        check("ovf_fault", {30'd0, fault, 1'b0} | 32'(fault_code), 32'h3);
        check("ovf_pc", 32'(pc), 32'h50);
        check("ovf_sp", 32'(sp), 32'h8);
        op_step(OP_MOV, 0);
        step(1'b0, OP_J, 'h1, 1'b0, 1'b0, 1'b1);
        check("ovf_frozen_pc", 32'(pc), 32'h50);
        do_reset();
        check("ovf_reset", {22'd0, pc}, 32'h0);
        check("ovf_reset_fc", {29'd0, fault, fault_code}, 32'h0);

        op_step(OP_RET, 0);
        check("udf_fault", {29'd0, fault, fault_code}, 32'h6);
        check("udf_pc", 32'(pc), 32'h0);

        do_reset();
        op_step(OP_J, 'h20);
        op_step(OP_HALT, 0);
        for (int i = 0; i < 10; i++) op_step(OP_J, 'h99);
        check("halt_halted", 32'(halted), 32'h1);
        check("halt_pc", 32'(pc), 32'h20);
        step(1'b0, OP_MOV, 0, 1'b0, 1'b1, 1'b1);
        check("halt_stall_resume", 32'(halted), 32'h1);
        step(1'b0, OP_MOV, 0, 1'b0, 1'b0, 1'b1);
        check("resume_pc", 32'(pc), 32'h21);
        check("resume_halted", 32'(halted), 32'h0);

        op_step(OP_J, 'h30);
        step(1'b0, OP_CALL, 'h80, 1'b0, 1'b1, 1'b0);
        check("stall_call_pc", 32'(pc), 32'h30);
        check("stall_call_sp", 32'(sp), 32'h0);
        op_step(OP_CALL, 'h80);
        op_step(OP_MOV, 0);
        check("call_once_pc", 32'(pc), 32'h81);
        check("call_once_sp", 32'(sp), 32'h1);

        op_step(OP_J, 'h3FF);
        op_step(OP_MOV, 0);
        check("pc_wrap", 32'(pc), 32'h0);
        op_step(OP_J, 'h3FF);
        op_step(OP_CALL, 'h5);
        op_step(OP_RET, 0);
        check("push_wrap", 32'(pc), 32'h0);

        op_step(OP_CALL, 'h123);
        step(1'b1, OP_CALL, 'h200, 1'b0, 1'b0, 1'b0);
        check("reset_call_pc", 32'(pc), 32'h0);
        check("reset_call_sp", 32'(sp), 32'h0);

        for (int i = 0; i < 4000; i++) begin
            int       r;
            logic [5:0] op;
            r = int'($urandom_range(0, 11));
            case (r)
                0:       op = OP_J;
                1:       op = OP_JZ;
                2:       op = OP_JNZ;
                3, 4, 5: op = OP_CALL;
                6, 7:    op = OP_RET;
                8:       op = ($urandom_range(0, 3) == 0) ? OP_HALT : OP_MOV;
                9:       op = 6'($urandom());
                default: op = OP_MOV;
            endcase
            step($urandom_range(0, 49) == 0, op, int'($urandom_range(0, PC_MOD - 1)),
                 1'($urandom()), $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0);
        end

        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
